// File: rtl/button_evt_pkg.sv
// Shared types and constants for the button event master and its FIFO.
package button_evt_pkg;

  typedef enum logic [2:0] {
    INIT,
    IDLE,
    RD,
    CAP,
    CLR,
    PUSH
  } state_t;

  localparam logic [1:0] PIO_ADDR_DATA = 2'd0;
  localparam logic [1:0] PIO_ADDR_MASK = 2'd2;
  localparam logic [1:0] PIO_ADDR_EDGE = 2'd3;

  localparam logic [7:0] OVF_CNT_MAX = 8'hFF;

  function automatic logic [7:0] sat_inc8(input logic [7:0] value);
    return (value == OVF_CNT_MAX) ? value : value + 8'd1;
  endfunction

endpackage

// File: rtl/button_evt_fifo.sv
// Small synchronous event FIFO; an extra pointer bit separates full from empty.
module button_evt_fifo
  import button_evt_pkg::*;
#(
  parameter int WIDTH = 2,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  // A push into a full FIFO is refused even when a pop happens alongside it.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                 (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign head  = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/button_event_master.sv
// Avalon-MM initiator servicing the button PIO edge-capture register into an event stream.
// Optional BUTTON_EVT_OVF_CNT_EN adds an 8-bit saturating dropped-event counter.
module button_event_master
  import button_evt_pkg::*;
#(
  parameter int             WIDTH      = 2,
  parameter logic [WIDTH-1:0] MASK     = 2'b11,
  parameter int             FIFO_DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             irq,
  output logic [1:0]       address,
  output logic             chipselect,
  output logic             write_n,
  output logic [31:0]      writedata,
  input  logic [31:0]      readdata,
  output logic             evt_valid,
  output logic [WIDTH-1:0] evt_data,
  input  logic             evt_ready,
  output logic             overflow
`ifdef BUTTON_EVT_OVF_CNT_EN
  ,
  output logic [7:0]       ovf_count
`endif
);

  state_t           state;
  logic [WIDTH-1:0] cap;
  logic             fifo_full;
  logic             fifo_empty;
  logic             push;
  logic             drop;
  logic             unused_readdata;

  assign unused_readdata = ^readdata[31:WIDTH];

  assign push = (state == PUSH) && (cap != '0) && !fifo_full;
  assign drop = (state == PUSH) && (cap != '0) &&  fifo_full;

  assign evt_valid = !fifo_empty;

  // Bus outputs are loaded on the edge that enters a state, so they line up
  // with the state they belong to; the INIT write shows up on the first cycle after reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= INIT;
      address    <= PIO_ADDR_DATA;
      chipselect <= 1'b0;
      write_n    <= 1'b1;
      writedata  <= '0;
      cap        <= '0;
      overflow   <= 1'b0;
    end else begin
      address    <= PIO_ADDR_DATA;
      chipselect <= 1'b0;
      write_n    <= 1'b1;
      writedata  <= '0;
      case (state)
        INIT: begin
          chipselect <= 1'b1;
          write_n    <= 1'b0;
          address    <= PIO_ADDR_MASK;
          writedata  <= 32'(MASK);
          state      <= IDLE;
        end
        IDLE: begin
          if (irq) begin
            chipselect <= 1'b1;
            address    <= PIO_ADDR_EDGE;
            state      <= RD;
          end
        end
        RD: begin
          state <= CAP;
        end
        CAP: begin
          cap        <= readdata[WIDTH-1:0];
          chipselect <= 1'b1;
          write_n    <= 1'b0;
          address    <= PIO_ADDR_EDGE;
          state      <= CLR;
        end
        CLR: begin
          state <= PUSH;
        end
        PUSH: begin
          if (drop) overflow <= 1'b1;
          state <= IDLE;
        end
        default: begin
          state <= INIT;
        end
      endcase
    end
  end

`ifdef BUTTON_EVT_OVF_CNT_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ovf_count <= '0;
    end else if (drop) begin
      ovf_count <= sat_inc8(ovf_count);
    end
  end
`endif

  button_evt_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (push),
    .push_data (cap),
    .pop       (evt_ready),
    .head      (evt_data),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

endmodule

// File: tb/tb_button_event_master.sv
// Directed bench for button_event_master with a behavioural two-bit PIO model.
module tb_button_event_master;

  logic        clk;
  logic        reset_n;
  logic        irq;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        evt_valid;
  logic [1:0]  evt_data;
  logic        evt_ready;
  logic        overflow;
`ifdef BUTTON_EVT_OVF_CNT_EN
  logic [7:0]  ovf_count;
`endif

  logic [1:0]  edge_cap;
  logic [1:0]  mask_reg;
  logic [1:0]  edge_set;
  logic        irq_extra;

  int assert_count = 0;
  int fail_count   = 0;

  button_event_master #(
    .WIDTH      (2),
    .MASK       (2'b11),
    .FIFO_DEPTH (4)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .irq        (irq),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .evt_valid  (evt_valid),
    .evt_data   (evt_data),
    .evt_ready  (evt_ready),
    .overflow   (overflow)
`ifdef BUTTON_EVT_OVF_CNT_EN
    ,
    .ovf_count  (ovf_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // PIO model: registered readdata, edge capture where the clear write wins.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      edge_cap <= 2'b00;
      mask_reg <= 2'b00;
      readdata <= 32'd0;
    end else begin
      readdata <= (address == 2'd3) ? {30'd0, edge_cap} :
                  (address == 2'd2) ? {30'd0, mask_reg} : 32'd0;
      if (chipselect && !write_n && address == 2'd2) mask_reg <= writedata[1:0];
      if (chipselect && !write_n && address == 2'd3) edge_cap <= 2'b00;
      else edge_cap <= edge_cap | edge_set;
    end
  end

  assign irq = (|(edge_cap & mask_reg)) | irq_extra;

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    assert_count++;
    assert (obs === exp) else begin
      fail_count++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic press(input logic [1:0] bits);
    @(negedge clk);
    edge_set = bits;
    @(negedge clk);
    edge_set = 2'b00;
  endtask

  initial begin
    logic [1:0] drain_exp [4];
    drain_exp[0] = 2'b01;
    drain_exp[1] = 2'b10;
    drain_exp[2] = 2'b11;
    drain_exp[3] = 2'b01;

    reset_n   = 1'b0;
    edge_set  = 2'b00;
    irq_extra = 1'b0;
    evt_ready = 1'b0;

    // Reset values while reset is held.
    repeat (3) @(negedge clk);
    check_output("rst_cs", chipselect, 1'b0);
    check_output("rst_wn", write_n, 1'b1);
    check_output("rst_addr", address, 2'd0);
    check_output("rst_wd", writedata, 32'd0);
    check_output("rst_valid", evt_valid, 1'b0);
    check_output("rst_ovf", overflow, 1'b0);

    // First bus cycle after release writes the irq mask.
    reset_n = 1'b1;
    @(negedge clk);
    check_output("init_cs", chipselect, 1'b1);
    check_output("init_wn", write_n, 1'b0);
    check_output("init_addr", address, 2'd2);
    check_output("init_wd", writedata, 32'd3);
    @(negedge clk);
    check_output("idle_cs", chipselect, 1'b0);
    check_output("idle_wn", write_n, 1'b1);
    check_output("idle_valid", evt_valid, 1'b0);
    repeat (2) @(negedge clk);

    // Single press of bit 0: cycle t is the one in which irq is first high.
    press(2'b01);
    @(negedge clk);
    check_output("t1_cs", chipselect, 1'b1);
    check_output("t1_wn", write_n, 1'b1);
    check_output("t1_addr", address, 2'd3);
    @(negedge clk);
    check_output("t2_cs", chipselect, 1'b0);
    @(negedge clk);
    check_output("t3_cs", chipselect, 1'b1);
    check_output("t3_wn", write_n, 1'b0);
    check_output("t3_addr", address, 2'd3);
    check_output("t3_wd", writedata, 32'd0);
    @(negedge clk);
    check_output("t4_valid", evt_valid, 1'b0);
    @(negedge clk);
    check_output("t5_valid", evt_valid, 1'b1);
    check_output("t5_data", evt_data, 2'b01);
    repeat (2) @(negedge clk);
    check_output("hold_data", evt_data, 2'b01);
    evt_ready = 1'b1;
    @(negedge clk);
    evt_ready = 1'b0;
    check_output("pop_valid", evt_valid, 1'b0);

    // irq with nothing captured: read and clear happen, nothing is queued.
    irq_extra = 1'b1;
    @(negedge clk);
    irq_extra = 1'b0;
    check_output("zero_rd_cs", chipselect, 1'b1);
    check_output("zero_rd_addr", address, 2'd3);
    repeat (5) @(negedge clk);
    check_output("zero_valid", evt_valid, 1'b0);
    check_output("zero_ovf", overflow, 1'b0);
    press(2'b10);
    @(negedge clk);
    check_output("after_zero_rd", chipselect, 1'b1);
    repeat (4) @(negedge clk);
    check_output("after_zero_valid", evt_valid, 1'b1);
    check_output("after_zero_data", evt_data, 2'b10);
    evt_ready = 1'b1;
    @(negedge clk);
    evt_ready = 1'b0;

    // Both buttons in one press form a single event.
    press(2'b11);
    repeat (8) @(negedge clk);
    check_output("both_valid", evt_valid, 1'b1);
    check_output("both_data", evt_data, 2'b11);
    evt_ready = 1'b1;
    @(negedge clk);
    evt_ready = 1'b0;
    check_output("both_single", evt_valid, 1'b0);

    // Five presses into a four-entry FIFO: the last one is dropped.
    press(2'b01); repeat (6) @(negedge clk);
    press(2'b10); repeat (6) @(negedge clk);
    press(2'b11); repeat (6) @(negedge clk);
    press(2'b01); repeat (6) @(negedge clk);
    check_output("full_no_ovf", overflow, 1'b0);
    press(2'b10); repeat (6) @(negedge clk);
    check_output("ovf_set", overflow, 1'b1);
`ifdef BUTTON_EVT_OVF_CNT_EN
    check_output("ovf_count", ovf_count, 8'd1);
`endif
    for (int i = 0; i < 4; i++) begin
      check_output("drain_valid", evt_valid, 1'b1);
      check_output("drain_data", evt_data, drain_exp[i]);
      evt_ready = 1'b1;
      @(negedge clk);
    end
    evt_ready = 1'b0;
    check_output("drain_empty", evt_valid, 1'b0);
    check_output("ovf_sticky", overflow, 1'b1);

    // Reset asserted during CLR with an event already queued.
    press(2'b01); repeat (6) @(negedge clk);
    check_output("pre_rst_valid", evt_valid, 1'b1);
    press(2'b10);
    repeat (3) @(negedge clk);
    check_output("clr_wn", write_n, 1'b0);
    reset_n = 1'b0;
    #1;
    check_output("mid_rst_cs", chipselect, 1'b0);
    check_output("mid_rst_wn", write_n, 1'b1);
    check_output("mid_rst_addr", address, 2'd0);
    check_output("mid_rst_wd", writedata, 32'd0);
    check_output("mid_rst_valid", evt_valid, 1'b0);
    check_output("mid_rst_ovf", overflow, 1'b0);
`ifdef BUTTON_EVT_OVF_CNT_EN
    check_output("mid_rst_cnt", ovf_count, 8'd0);
`endif
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check_output("reinit_cs", chipselect, 1'b1);
    check_output("reinit_wn", write_n, 1'b0);
    check_output("reinit_addr", address, 2'd2);
    check_output("reinit_wd", writedata, 32'd3);
    repeat (6) @(negedge clk);
    check_output("reinit_idle_cs", chipselect, 1'b0);
    check_output("reinit_valid", evt_valid, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
    $finish;
  end

endmodule

// File: doc/button_event_master.md
# button_event_master

Avalon-MM initiator that services the two-bit button PIO. After reset it programs the PIO interrupt mask, then on each PIO `irq` it reads the edge-capture register, clears it, and queues the captured edge bits in a small FIFO. Downstream logic reads the FIFO through a valid/ready stream, so button events are handled in hardware without Nios software.

## Interface
Parameters:
- `WIDTH`, 2: number of button bits. Must match the PIO data width.
- `MASK`, 2'b11: value written to the PIO irq_mask register (address 2) after reset.
- `FIFO_DEPTH`, 4: event FIFO entries. Power of two, ≥2.

Ports:
- `clk` in 1: single clock, shared with the PIO.
- `reset_n` in 1: asynchronous, active-low reset.
- `irq` in 1: PIO interrupt, level.
- `address` out 2: to PIO `address`.
- `chipselect` out 1: to PIO `chipselect`.
- `write_n` out 1: to PIO `write_n`. Active low.
- `writedata` out 32: to PIO `writedata`.
- `readdata` in 32: from PIO `readdata`. Registered in the PIO, fixed read latency 1.
- `evt_valid` out 1: FIFO non-empty.
- `evt_data` out WIDTH: oldest queued edge mask.
- `evt_ready` in 1: consumer accepts when `evt_valid && evt_ready`.
- `overflow` out 1: sticky. Set when an event is dropped because the FIFO is full. Cleared only by reset.

## Operation
- Bus outputs are registered.
- Reset values: `address`=0, `chipselect`=0, `write_n`=1, `writedata`=0, `evt_valid`=0, `overflow`=0. FIFO is empty and the FSM is in INIT.
- FSM states:
  - INIT: drive write, `address`=2, `writedata`={30'b0,MASK}. Next state is IDLE. Entered only from reset.
  - IDLE: bus idle (`chipselect`=0, `write_n`=1). If `irq`=1, go to RD.
  - RD: drive `chipselect`=1, `write_n`=1, `address`=3. Next state is CAP.
  - CAP: bus idle. Sample `readdata[WIDTH-1:0]` into `cap`. Next state is CLR.
  - CLR: drive write, `address`=3, `writedata`=0. This clears all PIO edge bits. Next state is PUSH.
  - PUSH: if `cap`≠0 and the FIFO is not full, push `cap`. If `cap`≠0 and the FIFO is full, drop `cap` and set `overflow`. If `cap`=0, do nothing. Next state is IDLE.
- A push and a pop in the same cycle are both honoured. A push when full is never accepted, even if a pop happens in the same cycle.
- `evt_data` is the FIFO head and is stable while `evt_valid && !evt_ready`.
- Known PIO limitation: an edge that arrives between the RD cycle and the CLR write strobe is lost, because clear wins in the PIO. This is accepted.

## Timing
- The PIO `readdata` reflects the address presented in the previous cycle. CAP samples the read issued in RD.
- `irq` seen at cycle t puts the FSM in RD at t+1, CAP at t+2, CLR at t+3 and PUSH at t+4. `evt_valid` rises at t+5 if the FIFO was empty.
- The PIO irq drops on the cycle after the CLR strobe, before the FSM re-enters IDLE. A stale `irq` therefore cannot retrigger.
- Minimum service period is 5 cycles per interrupt.
- An `irq` that arrives while the FSM is not in IDLE is serviced on the next IDLE visit. It is level, so it is not lost.
- Async reset mid-sequence: all outputs return to reset values immediately. The FIFO contents and the captured event are discarded, and INIT re-runs.

## Configuration
- `BUTTON_EVT_OVF_CNT_EN` defined:
  - adds output `ovf_count` (8 bits), a saturating count of dropped events;
  - it resets to 0 and sticks at 255.
- Not defined: the port and counter are absent. `overflow` behaves identically in both builds.

## Structure
- Shared package `button_evt_pkg`:
  - state enum (INIT, IDLE, RD, CAP, CLR, PUSH);
  - PIO address constants `PIO_ADDR_DATA`=0, `PIO_ADDR_MASK`=2, `PIO_ADDR_EDGE`=3.
- One sub-module, `button_evt_fifo`: synchronous FIFO with WIDTH and DEPTH parameters, push/pop, full/empty flags. Uses an extra-bit pointer scheme for full/empty.

## Test plan
- Reset release: the first bus cycle is a write with `address`=2 and `writedata`=3. After that the bus is idle and `evt_valid`=0.
- PIO model raises edge bit 0 at cycle t: the bench sees a read of address 3 at t+1, a write of address 3 with data 0 at t+3, and `evt_valid`=1 with `evt_data`=2'b01 at t+5.
- Both buttons edge together with `evt_ready` held 0: a single event 2'b11 is queued.
- With `evt_ready`=0, 5 separate presses: 4 events are queued, `overflow`=1, and `ovf_count`=1 when the macro is defined. Then assert `evt_ready`: the 4 events drain in order.
- Model returns `readdata`=0 while `irq` pulses: no push occurs and the FSM returns to IDLE.
- Assert `reset_n` low during the CLR state: outputs are at reset values immediately and INIT re-runs after release.
